// File: rtl/ram_8kx32_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_8kx32_wb_ctrl
// Purpose  : Wishbone B4 classic slave sequencing bus cycles into accesses of
//            the 8K x 32 banked DFFRAM. Optional macro RAM_WB_FAST_RD_EN
//            removes the read-capture stage (combinational DAT_O).
// Revision : 1.0 - initial release
// ============================================================================
module ram_8kx32_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        RAM_EN,
    output logic [3:0]  RAM_WE,
    output logic [12:0] RAM_A,
    output logic [31:0] RAM_Di,
    input  logic [31:0] RAM_Do
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [12:0] ram_a_q, ram_a_d;
    logic [31:0] ram_di_q, ram_di_d;
`ifndef RAM_WB_FAST_RD_EN
    logic [31:0] dat_q, dat_d;
`endif

    logic w_hit;
    logic w_accept;
    logic w_unused;

    // Byte offset within a word is irrelevant: all accesses are word-aligned.
    assign w_unused = ^ADR_I[1:0];
    assign w_hit    = (ADR_I[31:15] == BASE_ADDR[31:15]);
    assign w_accept = CYC_I & STB_I & (state_q == S_IDLE) & ~ACK_O & ~ERR_O;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ram_en_d = ram_en_q;
        ram_we_d = ram_we_q;
        ram_a_d  = ram_a_q;
        ram_di_d = ram_di_q;
`ifndef RAM_WB_FAST_RD_EN
        dat_d    = dat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        err_d    = 1'b0;
                        ram_a_d  = ADR_I[14:2];
                        ram_en_d = 1'b1;
                        if (WE_I) begin
                            state_d  = S_WR;
                            ram_di_d = DAT_I;
                            ram_we_d = SEL_I;
                        end else begin
                            state_d  = S_RD;
                            ram_we_d = 4'b0000;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WR: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'b0000;
                state_d  = S_RESP;
            end
            S_RD: begin
                // RAM_A is left untouched: the RAM output mux follows it.
                ram_en_d = 1'b0;
`ifdef RAM_WB_FAST_RD_EN
                state_d  = S_RESP;
`else
                state_d  = S_CAP;
`endif
            end
`ifndef RAM_WB_FAST_RD_EN
            S_CAP: begin
                dat_d   = RAM_Do;
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 4'b0000;
            ram_a_q  <= 13'd0;
            ram_di_q <= 32'd0;
`ifndef RAM_WB_FAST_RD_EN
            dat_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
            ram_a_q  <= ram_a_d;
            ram_di_q <= ram_di_d;
`ifndef RAM_WB_FAST_RD_EN
            dat_q    <= dat_d;
`endif
        end
    end

    // Responses are gated by CYC_I so an abandoned cycle is never acknowledged.
    assign ACK_O  = (state_q == S_RESP) & ~err_q & CYC_I;
    assign ERR_O  = (state_q == S_RESP) &  err_q & CYC_I;
    assign RAM_EN = ram_en_q;
    assign RAM_WE = ram_we_q;
    assign RAM_A  = ram_a_q;
    assign RAM_Di = ram_di_q;
`ifdef RAM_WB_FAST_RD_EN
    assign DAT_O  = ((state_q == S_RESP) && !err_q) ? RAM_Do : 32'd0;
`else
    assign DAT_O  = dat_q;
`endif

endmodule
`default_nettype wire
